// File: rtl/gpu_pkg.sv
// Shared encodings for the per-thread load/store unit: core phases, the
// externally visible LSU state and the internal access FSM.
package gpu_pkg;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam int         BYTE_BITS    = 8;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_RELEASE,
        S_WR_WAIT,
        S_WR_RELEASE,
        S_DONE
    } lsu_fsm_e;

    // Collapse the read/write halves of the FSM onto the four reported states.
    function automatic lsu_state_e fsm_to_lsu(input lsu_fsm_e s);
        case (s)
            S_RD_WAIT, S_WR_WAIT:       return LSU_REQUESTING;
            S_RD_RELEASE, S_WR_RELEASE: return LSU_WAITING;
            S_DONE:                     return LSU_DONE;
            default:                    return LSU_IDLE;
        endcase
    endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// Byte lane helper: sign-extended byte extract for loads and byte merge
// for the read-modify-write of byte stores.
module lsu_byte_lane
    import gpu_pkg::*;
#(
    parameter int DATA_BITS = 16
) (
    input  logic [DATA_BITS-1:0] word,
    input  logic                 lane,
    input  logic [BYTE_BITS-1:0] byte_data,
    output logic [DATA_BITS-1:0] ext,
    output logic [DATA_BITS-1:0] merged
);
    logic [BYTE_BITS-1:0] sel;

    always_comb begin
        sel    = word[BYTE_BITS-1:0];
        merged = word;
        if (lane) begin
            sel                                = word[2*BYTE_BITS-1:BYTE_BITS];
            merged[2*BYTE_BITS-1:BYTE_BITS]    = byte_data;
        end else begin
            merged[BYTE_BITS-1:0]              = byte_data;
        end
    end

    assign ext = {{(DATA_BITS-BYTE_BITS){sel[BYTE_BITS-1]}}, sel};
endmodule

// File: rtl/lsu.sv
// Per-thread load/store unit: effective address, valid/ready handshakes to
// the memory controller, byte loads with sign extension and RMW byte stores.
module lsu
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic                 decoded_mem_byte,
    input  logic                 decoded_byte_hi,
    input  logic [ADDR_BITS-1:0] decoded_offset,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);
    lsu_fsm_e             state;
    logic                 is_load, is_byte, byte_hi;
    logic [BYTE_BITS-1:0] st_byte;
    logic [ADDR_BITS-1:0] addr, ea;
    logic [DATA_BITS-1:0] old_word, lane_word, lane_ext, lane_merged;
    logic                 req, rd_req;

    assign ea     = rs[ADDR_BITS-1:0] + decoded_offset;
    assign req    = enable && (core_state == CORE_REQUEST);
    // A byte store needs the old word first, so it starts with a read.
    assign rd_req = decoded_mem_read_enable || (decoded_mem_write_enable && decoded_mem_byte);

    // Extract straight off the bus at capture; merge from the held word later.
    assign lane_word = (state == S_RD_WAIT) ? mem_read_data : old_word;

    lsu_byte_lane #(.DATA_BITS(DATA_BITS)) u_lane (
        .word      (lane_word),
        .lane      (byte_hi),
        .byte_data (st_byte),
        .ext       (lane_ext),
        .merged    (lane_merged)
    );

    assign mem_read_address  = addr;
    assign mem_write_address = addr;
    assign lsu_state         = fsm_to_lsu(state);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            is_load         <= 1'b0;
            is_byte         <= 1'b0;
            byte_hi         <= 1'b0;
            st_byte         <= '0;
            addr            <= '0;
            old_word        <= '0;
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            mem_write_data  <= '0;
            lsu_out         <= '0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    if (rd_req) begin
                        addr           <= ea;
                        is_load        <= decoded_mem_read_enable;
                        is_byte        <= decoded_mem_byte;
                        byte_hi        <= decoded_byte_hi;
                        st_byte        <= rt[BYTE_BITS-1:0];
                        mem_read_valid <= 1'b1;
                        state          <= S_RD_WAIT;
                    end else if (decoded_mem_write_enable) begin
                        addr            <= ea;
                        is_load         <= 1'b0;
                        is_byte         <= 1'b0;
                        mem_write_data  <= rt;
                        mem_write_valid <= 1'b1;
                        state           <= S_WR_WAIT;
                    end
                end
                S_RD_WAIT: if (mem_read_ready) begin
                    mem_read_valid <= 1'b0;
                    if (is_load) lsu_out <= is_byte ? lane_ext : mem_read_data;
                    else         old_word <= mem_read_data;
                    state <= S_RD_RELEASE;
                end
                S_RD_RELEASE: if (!mem_read_ready) begin
                    if (is_load) begin
                        state <= S_DONE;
                    end else begin
                        mem_write_data  <= lane_merged;
                        mem_write_valid <= 1'b1;
                        state           <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: if (mem_write_ready) begin
                    mem_write_valid <= 1'b0;
                    state           <= S_WR_RELEASE;
                end
                S_WR_RELEASE: if (!mem_write_ready) state <= S_DONE;
                S_DONE:       if (core_state == CORE_UPDATE) state <= S_IDLE;
                default:      state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/lsu.md
# lsu

Per-thread load/store unit sitting directly upstream of the memory `controller`: one instance per thread drives one consumer port of the data-memory controller. On the core's REQUEST phase it computes an effective address, issues a read or write using the controller's valid/ready handshake, and holds the result until the core's UPDATE phase. Supports 16-bit word access and int8 byte access: byte loads are sign-extended, and byte stores use a read-modify-write.

## Interface
Parameters:
- `ADDR_BITS`, 8, data-memory word address width
- `DATA_BITS`, 16, memory word width; byte mode requires exactly 16

Ports:
- `clk`  in  1  clock, all logic on posedge
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  thread active in this block
- `core_state`  in  3  core phase: REQUEST=3'b011, UPDATE=3'b110 (others ignored)
- `decoded_mem_read_enable`  in  1  instruction is a load
- `decoded_mem_write_enable`  in  1  instruction is a store
- `decoded_mem_byte`  in  1  0 = word access, 1 = byte access
- `decoded_byte_hi`  in  1  byte lane select: 0 = [7:0], 1 = [15:8]
- `decoded_offset`  in  ADDR_BITS  unsigned address offset
- `rs`  in  DATA_BITS  base register
- `rt`  in  DATA_BITS  store data
- `mem_read_valid`  out  1  read request to controller
- `mem_read_address`  out  ADDR_BITS
- `mem_read_ready`  in  1  controller read done; data valid while high
- `mem_read_data`  in  DATA_BITS
- `mem_write_valid`  out  1
- `mem_write_address`  out  ADDR_BITS
- `mem_write_data`  out  DATA_BITS
- `mem_write_ready`  in  1
- `lsu_state`  out  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3
- `lsu_out`  out  DATA_BITS  load result

## Operation
- Effective address: `ea = rs[ADDR_BITS-1:0] + decoded_offset`, modulo 2^ADDR_BITS (wraps, no flag).
- Internal FSM states: IDLE, RD_WAIT, RD_RELEASE, WR_WAIT, WR_RELEASE, DONE.
- IDLE: if `enable && core_state==REQUEST`:
  - load, or byte store: latch `ea`, set `mem_read_valid`=1, go to RD_WAIT.
  - word store: latch `ea` and `rt`, set `mem_write_valid`=1, go to WR_WAIT.
  - Read and write enable both high: treated as a load; the write is ignored.
  - Neither enable set: stay in IDLE.
- RD_WAIT: on `mem_read_ready`, clear `mem_read_valid` and capture the word, then go to RD_RELEASE.
  - Word load: `lsu_out` = word.
  - Byte load: `lsu_out` = sign-extended selected byte.
  - Byte store: the word is held for the merge.
- RD_RELEASE: hold until `mem_read_ready`==0 (no back-to-back request while the controller is still relaying), then:
  - load: go to DONE.
  - byte store: set `mem_write_data` = old word with the selected lane replaced by `rt[7:0]`, set `mem_write_valid`=1, same address, go to WR_WAIT.
- WR_WAIT: on `mem_write_ready`, clear `mem_write_valid`, go to WR_RELEASE.
- WR_RELEASE: when `mem_write_ready`==0, go to DONE.
- DONE: when `core_state==UPDATE`, go to IDLE; `lsu_out` is retained.
- `lsu_state` mapping: IDLE→0, RD_WAIT/WR_WAIT→1, RD_RELEASE/WR_RELEASE→2, DONE→3.
- `enable` and `core_state` are sampled only in IDLE and DONE. An in-flight access always completes.

## Timing
- Reset drives every output and state register to 0 (FSM to IDLE).
  - Reset mid-transaction abandons the access.
  - Valids drop the next edge.
- Request latency: valid is high the edge after the REQUEST cycle.
- Address and data are stable for the entire time valid is high.
- Handshake rules:
  - Valid stays high until ready is sampled high.
  - Valid drops the following edge.
  - No new valid is raised while the matching ready is still high.
- Word load and word store: 1 cycle to issue, plus N wait cycles, plus at least 1 release cycle, then DONE.
- Byte store: two complete handshakes, read then write. The write valid rises on the edge after ready is seen low.
- `lsu_out` updates only at the capture edge of a load; stores leave it unchanged.

## Structure
- Shared package `gpu_pkg`:
  - `core_state` encodings
  - `lsu_state` encodings
  - internal FSM enum
  - `BYTE_BITS`=8
- Sub-module `lsu_byte_lane`: combinational byte extract with sign extension and byte merge. Inputs: word, lane, byte. Outputs: extended byte, merged word.
- The top `lsu` holds the FSM and registers.

## Test plan
- Word load: rs=0x0010, offset=0x05; mem[0x15]=0xBEEF returned after 3 wait cycles → read address 0x15, valid held 4 cycles, `lsu_out`=0xBEEF, `lsu_state`=3 until UPDATE.
- Byte load, hi lane: mem[0x20]=0x80_7F → `lsu_out`=0xFF80; lo lane → 0x007F.
- Byte store: mem[0x30]=0x1234, rt=0x00AB, hi lane → read 0x30, then write 0x30 with data 0xAB34; exactly one read and one write valid pulse train.
- Address wrap and priority: rs=0x00F0, offset=0x20 → address 0x10. Read and write enables both high → read only; `mem_write_valid` stays 0.
- Held ready: controller keeps `mem_read_ready` high 3 extra cycles → FSM stays in RD_RELEASE and no new valid is issued; a REQUEST during DONE is ignored.
- Reset asserted while in RD_WAIT → next edge all outputs 0, FSM in IDLE; a fresh request afterwards completes normally.
